// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width, state encoding
// and the bit-counter sizing helper.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Counter must hold values 0..width so it never wraps before the last bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_add.sv
// Single-bit full adder cell used by the serial datapath.
//   a, b  : operand bits
//   c     : carry in
//   cout  : carry out
//   s     : sum bit
module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic cout,
    output logic s
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: a + b + cin, one bit per clock, LSB first,
// behind a start/busy/done handshake.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, honoured only when idle
//   a, b  : operands, captured on an accepted start
//   cin   : carry in, captured on an accepted start
//   busy  : high while an operation is in RUN or DONE
//   done  : one-cycle pulse when sum/cout have just been updated
//   sum   : (a+b+cin) mod 2^WIDTH, held until the next completion
//   cout  : carry out of the top bit
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    count;
    logic             load;
    logic             shift;
    logic             finish;
    logic             busy_nxt;
    logic             s_bit;
    logic             c_next;

    // The one adder cell; everything else is shifting around it.
    full_add u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (carry),
        .cout (c_next),
        .s    (s_bit)
    );

    // Next-state and datapath controls.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    load      = 1'b1;
                end
            end
            S_RUN: begin
                shift = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_DONE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift registers, carry flop, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= finish;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                count <= '0;
            end
            if (shift) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                carry <= c_next;
                // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                res   <= (res >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                count <= count + CW'(1);
            end
            if (finish) begin
                sum  <= res;
                cout <= carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int unsigned W  = 10;
    localparam int unsigned W1 = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timing model: an accepted op keeps busy for W+1 cycles, then result and done appear.
    int          m_rem  = 0;
    logic [W:0]  m_pend = '0;
    logic [W:0]  m_res  = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = '0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (start) begin
                m_rem  = W + 1;
                m_pend = {1'b0, a} + {1'b0, b} + W1'(cin);
            end
            m_busy = (m_rem > 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle", 32'({busy, done, cout, sum}), 32'({m_busy, m_done, m_res[W], m_res[W-1:0]}));
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                          input logic [W:0] exp, input string name,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 3 * W + 10; i++) begin
            if (i > 1) @(negedge clk);
            if (done) begin
                lat = i - 1;
                break;
            end
            if (busy) bcnt++;
        end
        check({name, "_done"}, 32'(done), 32'(1));
        check({name, "_sum"}, 32'({cout, sum}), 32'(exp));
    endtask

    task automatic run_op1(input logic ta, input logic tbv, input logic tc,
                           input logic [1:0] exp, input string name);
        int lat;
        @(negedge clk);
        a1 = ta; b1 = tbv; cin1 = tc; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            if (done1) begin
                lat = i - 1;
                break;
            end
        end
        check({name, "_done"}, 32'(done1), 32'(1));
        check({name, "_lat"}, 32'(lat), 32'(2));
        check({name, "_sum"}, 32'({cout1, sum1}), 32'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int lat;
        int bcnt;
        int n;
        int idx[2];
        logic [W:0] val[2];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;
        int ndone;
        logic [W:0] cap;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum",  32'({cout, sum}), 32'(0));
        check("rst_w1",   32'({busy1, done1, cout1, sum1}), 32'(0));
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        // 1: basic add, latency and busy length
        run_op(10'd500, 10'd499, 1'b0, 11'd999, "t1", lat, bcnt);
        check("t1_lat",  32'(lat),  32'(11));
        check("t1_busy", 32'(bcnt), 32'(11));

        // 2: overflow boundary and carry-in only
        run_op(10'd1023, 10'd1, 1'b0, 11'h400, "t2a", lat, bcnt);
        run_op(10'd0, 10'd0, 1'b1, 11'd1, "t2b", lat, bcnt);

        // 3: start during RUN is ignored
        @(negedge clk);
        a = 10'd100; b = 10'd23; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 10'd7; b = 10'd7; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap = {cout, sum};
            end
        end
        check("t3_pulses", 32'(ndone), 32'(1));
        check("t3_sum", 32'(cap), 32'(124));

        // 4: start held high, back-to-back ops
        @(negedge clk);
        a = 10'd100; b = 10'd200; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 10'd300; b = 10'd400;
        n = 0;
        idx[0] = 0; idx[1] = 0; val[0] = '0; val[1] = '0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (done) begin
                idx[n] = i;
                val[n] = {cout, sum};
                n++;
                if (n == 2) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("t4_count", 32'(n), 32'(2));
        check("t4_gap", 32'(idx[1] - idx[0]), 32'(12));
        check("t4_sum0", 32'(val[0]), 32'(300));
        check("t4_sum1", 32'(val[1]), 32'(700));
        repeat (15) @(negedge clk);

        // 5: reset mid-RUN aborts the op and clears outputs
        a = 10'd500; b = 10'd1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_done", 32'(done), 32'(0));
        check("t5_sum",  32'({cout, sum}), 32'(0));
        repeat (15) @(negedge clk);
        check("t5_nodone", 32'({busy, done}), 32'(0));
        run_op(10'd12, 10'd30, 1'b0, 11'd42, "t5_fresh", lat, bcnt);
        check("t5_lat", 32'(lat), 32'(11));

        // 6: random operands against plain arithmetic
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom_range(0, 1023));
            rb = W'($urandom_range(0, 1023));
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + W1'(rc), "t6", lat, bcnt);
        end

        // WIDTH=1 instance
        run_op1(1'b1, 1'b1, 1'b1, 2'b11, "w1_111");
        run_op1(1'b0, 1'b1, 1'b0, 2'b01, "w1_010");
        run_op1(1'b1, 1'b1, 1'b0, 2'b10, "w1_110");
        run_op1(1'b0, 1'b0, 1'b0, 2'b00, "w1_000");

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
